ssd_scroll_ctrl: RTL

// Controller that sequences the 4-digit seven-segment display datapath. Accepts a hex

---
 rtl/ssd_scroll_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ssd_scroll_ctrl.sv
// ssd_scroll_ctrl: sequences the 16-bit display word for the 4-digit seven-segment
// datapath. A hex message of up to MSG_NIB nibbles is accepted over valid/ready;
// messages of 4 nibbles or fewer are shown statically, longer ones are scrolled
// one nibble per programmable period, either looping or holding on the last window.
module ssd_scroll_ctrl #(
   parameter int MSG_NIB = 8,
   parameter int TICK_W  = 24,
   localparam int LEN_W  = $clog2(MSG_NIB + 1),
   localparam int POS_W  = $clog2(MSG_NIB)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   msg_valid,
   output logic                   msg_ready,
   input  logic [4*MSG_NIB-1:0]   msg_data,
   input  logic [LEN_W-1:0]       msg_len,
   input  logic                   msg_loop,
   input  logic [TICK_W-1:0]      scroll_period,
   input  logic                   enable,
   output logic [15:0]            data_out,
   output logic                   busy,
   output logic                   done,
   output logic [POS_W-1:0]       pos
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STATIC = 2'd1;
   localparam logic [1:0] SCROLL = 2'd2;
   localparam logic [1:0] HOLD   = 2'd3;

   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

   logic [1:0]             state;
   logic [4*MSG_NIB-1:0]   data_r;
   logic [LEN_W-1:0]       len_r;
   logic                   loop_r;
   logic [TICK_W-1:0]      per_m1;
   logic [TICK_W-1:0]      counter;
   logic [LEN_W-1:0]       len_eff;
   logic [POS_W-1:0]       last_pos;
   logic                   accept;

   // Window at offset p of a message of len nibbles: digit k shows nibble len-4-p+k,
   // so offset 0 shows the leftmost (most significant) four nibbles.
   function automatic logic [15:0] scroll_win(input logic [4*MSG_NIB-1:0] d,
                                              input int len, input int p);
      logic [15:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         w[4*k +: 4] = d[4*(len - 4 - p + k) +: 4];
      end
      return w;
   endfunction

   // Short messages are shown right-aligned; nibbles beyond the length are blanked to 0.
   function automatic logic [15:0] static_win(input logic [4*MSG_NIB-1:0] d,
                                              input int len);
      logic [15:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < len) begin
            w[4*k +: 4] = d[4*k +: 4];
         end
      end
      return w;
   endfunction

   // Normalise the offered length: 0 counts as one nibble, oversize clamps to MSG_NIB.
   always_comb begin
      len_eff = msg_len;
      if (msg_len == '0) begin
         len_eff = LEN_W'(1);
      end else if (msg_len > LEN_W'(MSG_NIB)) begin
         len_eff = LEN_W'(MSG_NIB);
      end
   end

   assign accept    = msg_valid & msg_ready;
   assign msg_ready = (state != SCROLL);
   assign busy      = (state == SCROLL);
   assign last_pos  = POS_W'(len_r - LEN_W'(4));

   // Message capture, scroll stepping and display word update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         data_out <= '0;
         pos      <= '0;
         done     <= 1'b0;
         counter  <= '0;
         data_r   <= '0;
         len_r    <= LEN_W'(1);
         loop_r   <= 1'b0;
         per_m1   <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            data_r  <= msg_data;
            len_r   <= len_eff;
            loop_r  <= msg_loop;
            // Store period-1 so the terminal count compare needs no subtractor;
            // a zero period behaves as one step per cycle.
            per_m1  <= (scroll_period == '0) ? '0 : scroll_period - TICK_W'(1);
            pos     <= '0;
            counter <= '0;
            if (len_eff <= LEN_W'(4)) begin
               state    <= STATIC;
               data_out <= static_win(msg_data, int'(len_eff));
            end else begin
               state    <= SCROLL;
               data_out <= scroll_win(msg_data, int'(len_eff), 0);
            end
         end else if (state == SCROLL && enable) begin
            if (counter == per_m1) begin
               counter <= '0;
               if (pos < last_pos) begin
                  pos      <= pos + POS_ONE;
                  data_out <= scroll_win(data_r, int'(len_r), int'(pos) + 1);
                  done     <= ((pos + POS_ONE) == last_pos);
               end else if (loop_r) begin
                  pos      <= '0;
                  data_out <= scroll_win(data_r, int'(len_r), 0);
               end else begin
                  // Last window already shown for a full period: park on it.
                  state <= HOLD;
               end
            end else begin
               counter <= counter + TICK_W'(1);
            end
         end
      end
   end

endmodule
